stream_sequencer: RTL and testbench
===================================

STREAM_SEQUENCER -- requirements
Module: stream_sequencer

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per row (≥4).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, rows per frame (≥3).
REQ-003 SHALL have parameter PIXEL_SIZE, default 24, pixel bus width.
REQ-004 SHALL have parameter LATENCY, default 2*FRAME_WIDTH+2, pipeline enable-cycles from input pixel to its output (≥1).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  single-cycle frame start request.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_data input PIXEL_SIZE: source pixel handshake.
REQ-009 SHALL have ports pipe_en output 1, pipe_hsync output 1, pipe_vsync output 1, pipe_data output PIXEL_SIZE: drive to the detection pipeline.
REQ-010 SHALL have port pipe_out  input  PIXEL_SIZE  pipeline result bus.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_data output PIXEL_SIZE: sink handshake.
REQ-012 SHALL have ports busy output 1 (state≠IDLE) and frame_done output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM IDLE→STREAM (start in IDLE)→FLUSH (after TOTAL=FRAME_WIDTH*FRAME_HEIGHT STREAM steps)→DONE (after LATENCY FLUSH steps)→IDLE (unconditional, next cycle).
REQ-014 SHALL define primed = (issued ≥ LATENCY), issued = count of steps in current frame, width $clog2(TOTAL+LATENCY+1).
REQ-015 SHALL compute step combinationally: STREAM: in_valid & (!primed | out_ready); FLUSH: (!primed | out_ready); else 0.
REQ-016 SHALL drive pipe_en = step; no pipeline advance when out_valid & !out_ready (stall).
REQ-017 SHALL drive in_ready = (state==STREAM) & (!primed | out_ready), independent of in_valid.
REQ-018 SHALL drive pipe_data = in_data in STREAM, 0 in FLUSH and other states.
REQ-019 SHALL maintain col (0..FRAME_WIDTH-1) and row (0..FRAME_HEIGHT-1), advanced on STREAM steps only; col wraps to 0 and row increments at col==FRAME_WIDTH-1.
REQ-020 SHALL assert pipe_hsync on a STREAM step with col==FRAME_WIDTH-1 and row≠FRAME_HEIGHT-1 (last pixel of row).
REQ-021 SHALL assert pipe_vsync (not hsync) on the STREAM step with col==FRAME_WIDTH-1, row==FRAME_HEIGHT-1; hsync/vsync never asserted in FLUSH or without pipe_en.
REQ-022 SHALL drive out_valid = primed & ((STREAM & in_valid) | FLUSH); out_data = pipe_out, passed combinationally.
REQ-023 SHALL deliver exactly TOTAL outputs per frame, in input order.
REQ-024 SHALL clear issued, col, row on entry to STREAM.
REQ-025 SHALL ignore start when not IDLE.
REQ-026 SHALL assert frame_done only in DONE, for exactly one cycle; busy low only in IDLE.
REQ-027 SHALL hold all counters and state across cycles with step=0 (source or sink stall of any length).

Reset
REQ-028 SHALL on reset_n low, immediately (asynchronously) enter IDLE, clear issued/col/row; all outputs 0 (pipe_en, pipe_hsync, pipe_vsync, pipe_data, in_ready, out_valid, busy, frame_done), out_data follows pipe_out.
REQ-029 SHALL on reset mid-frame abandon the frame; no frame_done; next frame requires new start.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=3, LATENCY=5, TOTAL=12)
REQ-030 SHALL cover: start, in_valid=1, out_ready=1 continuous -> 17 pipe_en cycles, hsync at steps 3 and 7, vsync at step 11, out_valid on steps 5..16 (12 outputs), frame_done on cycle after step 16.
REQ-031 SHALL cover: in_valid low 3 cycles at step 6 -> pipe_en, in_ready-gated transfers and out_valid low those cycles; counters frozen; outputs still 12, ordered.
REQ-032 SHALL cover: out_ready low 4 cycles at step 9 -> pipe_en=0, in_ready=0, out_valid=1 held with stable out_data; resumes without loss/duplication.
REQ-033 SHALL cover: out_ready=0 from start -> steps 0..4 proceed (unprimed), then stall at step 5 until out_ready=1.
REQ-034 SHALL cover: start pulsed during STREAM -> ignored, frame completes normally in 17 steps, single frame_done.
REQ-035 SHALL cover: reset_n low at step 8 -> all outputs 0 same cycle, IDLE, no frame_done; subsequent start runs full 17-step frame with hsync at step 3.

Source files
------------

// File: rtl/stream_sequencer.sv
// Frame sequencer: feeds FRAME_WIDTH x FRAME_HEIGHT pixels into an enable-gated pipeline, then flushes LATENCY steps.
// Latency: out_data is pipe_out passed straight through; the pipeline result appears LATENCY pipe_en steps after its input.
// Backpressure: once primed, a sink stall freezes the pipeline and the source; unprimed steps ignore out_ready.
module stream_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int PIXEL_SIZE   = 24,
    parameter int LATENCY      = 2*FRAME_WIDTH+2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIXEL_SIZE-1:0] in_data,
    output logic                  pipe_en,
    output logic                  pipe_hsync,
    output logic                  pipe_vsync,
    output logic [PIXEL_SIZE-1:0] pipe_data,
    input  logic [PIXEL_SIZE-1:0] pipe_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIXEL_SIZE-1:0] out_data,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + LATENCY + 1);
    localparam int COL_W = $clog2(FRAME_WIDTH);
    localparam int ROW_W = $clog2(FRAME_HEIGHT);

    localparam logic [CNT_W-1:0] LAT_CNT     = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(TOTAL + LATENCY - 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] issued;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic in_stream;
    logic in_flush;
    logic primed;
    logic can_advance;
    logic step;
    logic row_end;

    assign in_stream   = (state == STREAM);
    assign in_flush    = (state == FLUSH);
    assign primed      = (issued >= LAT_CNT);
    // Until the pipeline holds LATENCY pixels nothing valid reaches the sink, so its ready is irrelevant.
    assign can_advance = !primed || out_ready;
    assign step        = (in_stream && in_valid && can_advance) || (in_flush && can_advance);
    assign row_end     = (col == COL_LAST);

    assign in_ready   = in_stream && can_advance;
    assign pipe_en    = step;
    assign pipe_data  = in_stream ? in_data : '0;
    assign pipe_hsync = in_stream && step && row_end && (row != ROW_LAST);
    assign pipe_vsync = in_stream && step && row_end && (row == ROW_LAST);
    assign out_valid  = primed && ((in_stream && in_valid) || in_flush);
    assign out_data   = pipe_out;
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            issued <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= STREAM;
                        issued <= '0;
                        col    <= '0;
                        row    <= '0;
                    end
                end
                STREAM: begin
                    if (step) begin
                        issued <= issued + 1'b1;
                        if (row_end) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (issued == STREAM_LAST) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (step) begin
                        issued <= issued + 1'b1;
                        if (issued == FLUSH_LAST) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_sequencer.sv
// Bench for stream_sequencer: a mock enable-gated delay line stands in for the detection pipeline,
// and a pixel queue plus frame-phase model supplies every expected value.
module tb_stream_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 5;
    localparam int P = 8;
    localparam int T = W * H;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] in_data;
    logic         pipe_en;
    logic         pipe_hsync;
    logic         pipe_vsync;
    logic [P-1:0] pipe_data;
    logic [P-1:0] pipe_out;
    logic         out_valid;
    logic         out_ready;
    logic [P-1:0] out_data;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    stream_sequencer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .PIXEL_SIZE  (P),
        .LATENCY     (L)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pipe_en   (pipe_en),
        .pipe_hsync(pipe_hsync),
        .pipe_vsync(pipe_vsync),
        .pipe_data (pipe_data),
        .pipe_out  (pipe_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    // Mock pipeline: L enable-gated stages
    logic [P-1:0] pl [L];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < L; i++) pl[i] <= '0;
        end else if (pipe_en) begin
            pl[0] <= pipe_data;
            for (int i = 1; i < L; i++) pl[i] <= pl[i-1];
        end
    end
    assign pipe_out = pl[L-1];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model state
    bit           active = 1'b0;
    int           steps = 0;
    logic [P-1:0] exp_q [$];
    int           f_steps = 0, f_outs = 0, f_done = 0, h_cnt = 0;
    int           h0 = -1, h1 = -1, v_at = -1, first_ov = -1;
    bit           hold_prev = 1'b0;
    logic [P-1:0] hold_dat = '0;

    always @(negedge clk) begin : mon
        logic str, fl, adv, e_ir, e_en, e_ov, e_hs, e_vs;
        int   old_steps;
        bit   was_active;
        if (!reset_n) begin
            chk("rst_outputs", {17'd0, pipe_en, pipe_hsync, pipe_vsync, in_ready, out_valid, busy, frame_done, pipe_data}, 0);
            chk("rst_out_data", out_data, pipe_out);
            active = 1'b0;
            steps = 0;
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            old_steps  = steps;
            was_active = active;
            str  = active && (steps < T);
            fl   = active && (steps >= T) && (steps < T + L);
            adv  = (steps < L) || out_ready;
            e_ir = str && adv;
            e_en = (e_ir && in_valid) || (fl && adv);
            e_ov = active && (steps >= L) && ((str && in_valid) || fl);
            e_hs = e_en && str && (steps % W == W - 1) && (steps / W != H - 1);
            e_vs = e_en && str && (steps == T - 1);
            chk("busy", busy, active);
            chk("frame_done", frame_done, active && (steps == T + L));
            chk("in_ready", in_ready, e_ir);
            chk("pipe_en", pipe_en, e_en);
            chk("out_valid", out_valid, e_ov);
            chk("pipe_data", pipe_data, str ? in_data : '0);
            chk("pipe_hsync", pipe_hsync, e_hs);
            chk("pipe_vsync", pipe_vsync, e_vs);
            chk("out_data_pass", out_data, pipe_out);
            if (hold_prev && (fl || (str && in_valid)))
                chk("held_out_data", out_data, hold_dat);
            hold_prev = out_valid && !out_ready;
            hold_dat  = out_data;

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_underflow", 1, 0);
                else chk("out_order", out_data, exp_q.pop_front());
                if (f_outs == 0) first_ov = steps;
                f_outs++;
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (pipe_en) begin
                if (pipe_hsync) begin
                    if (h_cnt == 0) h0 = steps;
                    else if (h_cnt == 1) h1 = steps;
                    h_cnt++;
                end
                if (pipe_vsync) v_at = steps;
                steps++;
                f_steps++;
            end
            if (frame_done) f_done++;
            if (was_active && old_steps == T + L) active = 1'b0;
            else if (!was_active && start) begin
                active = 1'b1;
                steps = 0;
            end
        end
    end

    typedef struct {
        int iv_at, iv_len, or_at, or_len, start_at;
        int exp_steps, exp_outs, exp_done, exp_h0, exp_h1, exp_v, exp_first;
    } vec_t;

    vec_t vt [5];

    task automatic clr_stats();
        f_steps = 0; f_outs = 0; f_done = 0; h_cnt = 0;
        h0 = -1; h1 = -1; v_at = -1; first_ov = -1;
    endtask

    task automatic run_frame(input vec_t v, input bit rnd);
        int iv_left = 0, or_left = 0, post = 0;
        bit iv_t = 0, or_t = 0, st_f = 0, fin = 0;
        clr_stats();
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == 0);
            if (cyc > 0 && !st_f && active && steps == v.start_at) begin
                start = 1'b1;
                st_f = 1'b1;
            end
            if (!iv_t && active && steps == v.iv_at) begin iv_t = 1; iv_left = v.iv_len; end
            if (!or_t && active && steps == v.or_at) begin or_t = 1; or_left = v.or_len; end
            in_valid  = rnd ? ($urandom_range(0, 3) != 0) : (iv_left == 0);
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : (or_left == 0);
            if (iv_left > 0) iv_left--;
            if (or_left > 0) or_left--;
            in_data = P'($urandom);
            if (f_done > 0) begin
                post++;
                if (post >= 3) fin = 1;
            end
        end
        start = 1'b0;
        if (!fin) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_frame(input string tag, input vec_t v);
        chk({tag, "_steps"}, f_steps, v.exp_steps);
        chk({tag, "_outs"}, f_outs, v.exp_outs);
        chk({tag, "_done"}, f_done, v.exp_done);
        chk({tag, "_hsync0"}, h0, v.exp_h0);
        chk({tag, "_hsync1"}, h1, v.exp_h1);
        chk({tag, "_hcnt"}, h_cnt, 2);
        chk({tag, "_vsync"}, v_at, v.exp_v);
        chk({tag, "_first_out"}, first_ov, v.exp_first);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (f_done == 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (f_done == 0) chk("wait_done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{-1, 0, -1, 0, -1, 17, 12, 1, 3, 7, 11, 5};  // continuous flow
        vt[1] = '{ 6, 3, -1, 0, -1, 17, 12, 1, 3, 7, 11, 5};  // source gap at step 6
        vt[2] = '{-1, 0,  9, 4, -1, 17, 12, 1, 3, 7, 11, 5};  // sink stall at step 9
        vt[3] = '{-1, 0,  0, 8, -1, 17, 12, 1, 3, 7, 11, 5};  // sink not ready from start
        vt[4] = '{-1, 0, -1, 0,  4, 17, 12, 1, 3, 7, 11, 5};  // stray start mid-frame

        reset_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hA5;
        #2;
        chk("init_outputs", {17'd0, pipe_en, pipe_hsync, pipe_vsync, in_ready, out_valid, busy, frame_done, pipe_data}, 0);
        chk("init_out_data", out_data, pipe_out);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(vt[i], 1'b0);
            check_frame($sformatf("vec%0d", i), vt[i]);
        end

        for (int r = 0; r < 6; r++) begin
            run_frame(vt[0], 1'b1);
            check_frame($sformatf("rnd%0d", r), vt[0]);
        end

        // Sink never ready: unprimed steps proceed, then freeze at step L
        clr_stats();
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_data = 8'h11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_steps", steps, L);
        chk("stall_pipe_en", pipe_en, 0);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_done();
        chk("stall_frame_steps", f_steps, 17);
        chk("stall_frame_outs", f_outs, 12);
        chk("stall_q_empty", exp_q.size(), 0);

        // Reset mid-frame at step 8
        clr_stats();
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h3C;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 50 && steps != 8; n++) begin
            @(posedge clk); #1;
        end
        chk("rst_at_step", steps, 8);
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", {17'd0, pipe_en, pipe_hsync, pipe_vsync, in_ready, out_valid, busy, frame_done, pipe_data}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_done", f_done, 0);
        chk("midrst_idle", busy, 0);
        run_frame(vt[0], 1'b0);
        check_frame("after_rst", vt[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
